// File: rtl/jk_bank_if.sv
// Bundle between the requesters and the JK bit bank arbiter: commands in,
// grant and bank state out.
interface jk_bank_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned NBITS = 8
);
   localparam int unsigned IDX_W = $clog2(NBITS);
   localparam int unsigned CNT_W = 16;

   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       j;
   logic [NREQ-1:0]       k;
   logic [IDX_W*NREQ-1:0] sel;
   logic [NREQ-1:0]       gnt;
   logic [NBITS-1:0]      q;
   logic [CNT_W-1:0]      op_cnt;

   modport master (output req, j, k, sel, input gnt, q, op_cnt);
   modport slave  (input req, j, k, sel, output gnt, q, op_cnt);
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting one requester per cycle a JK update on one bit
// of a shared register bank; counts updates that actually flipped a bit.
module jk_bank_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned NBITS = 8
) (
   input logic         clk,
   input logic         rst,
   jk_bank_if.slave    bus
);
   localparam int unsigned PTR_W = $clog2(NREQ);
   localparam int unsigned IDX_W = $clog2(NBITS);
   localparam int unsigned CNT_W = 16;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [NBITS-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [NREQ-1:0]  gnt_c;
   logic [PTR_W-1:0] gidx_c;
   logic             found_c;
   logic [IDX_W-1:0] sel_c;
   logic             old_c;
   logic             new_c;

   // Search from ptr upward (mod NREQ); reset masks every grant.
   always_comb begin
      logic [PTR_W-1:0] idx;
      gnt_c   = '0;
      gidx_c  = '0;
      found_c = 1'b0;
      idx     = '0;
      if (!rst) begin
         for (int unsigned off = 0; off < NREQ; off++) begin
            idx = PTR_W'(ptr_q + PTR_W'(off));
            if (!found_c && bus.req[idx]) begin
               found_c     = 1'b1;
               gidx_c      = idx;
               gnt_c[idx]  = 1'b1;
            end
         end
      end
   end

   // Command decode of the winning requester and next-state update.
   always_comb begin
      ptr_d = ptr_q;
      q_d   = q_q;
      cnt_d = cnt_q;
      sel_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gidx_c == PTR_W'(i)) sel_c = bus.sel[i*IDX_W +: IDX_W];
      end
      old_c = q_q[sel_c];
      unique case ({bus.j[gidx_c], bus.k[gidx_c]})
         2'b00:   new_c = old_c;
         2'b01:   new_c = 1'b0;
         2'b10:   new_c = 1'b1;
         default: new_c = ~old_c;
      endcase
      if (found_c) begin
         q_d[sel_c] = new_c;
         ptr_d      = PTR_W'(gidx_c + PTR_W'(1));
         if (new_c != old_c) cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.gnt    = gnt_c;
   assign bus.q      = q_q;
   assign bus.op_cnt = cnt_q;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: stimulus queues expected grant/q/op_cnt
// per accepted command, a negedge monitor pops and compares.
module tb_jk_bank_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   jk_bank_if #(.NREQ(4), .NBITS(8)) bus ();
   jk_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [3:0]  gnt;
      logic [7:0]  q;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   pend   = 1'b0;
   exp_t pend_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [3:0] g, input logic [7:0] qv, input logic [15:0] c);
      exp_t e;
      e.gnt = g; e.q = qv; e.cnt = c;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] jj, input logic [3:0] kk,
                        input logic [11:0] s);
      bus.req = r; bus.j = jj; bus.k = kk; bus.sel = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] sel_of(input logic [2:0] s0, input logic [2:0] s1,
                                          input logic [2:0] s2, input logic [2:0] s3);
      return {s3, s2, s1, s0};
   endfunction

   // Monitor: grant compared when seen, bank state one edge later.
   always @(negedge clk) begin
      if (pend) begin
         chk("q", 32'(bus.q), 32'(pend_e.q));
         chk("op_cnt", 32'(bus.op_cnt), 32'(pend_e.cnt));
         pend = 1'b0;
      end
      if (bus.gnt != 4'b0000) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_gnt actual=%b required=none", bus.gnt);
         end else begin
            pend_e = sb.pop_front();
            chk("gnt", 32'(bus.gnt), 32'(pend_e.gnt));
            pend = 1'b1;
         end
      end
   end

   initial begin
      rst = 1'b1;
      drive(4'b1111, 4'b1111, 4'b1111, 12'h000);
      @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      tick(); tick();
      chk("rst_q", 32'(bus.q), 32'h00);
      chk("rst_op_cnt", 32'(bus.op_cnt), 32'h0);

      // Single set of bit 3 by requester 0
      rst = 1'b0;
      drive(4'b0001, 4'b0001, 4'b0000, sel_of(3'd3, 3'd0, 3'd0, 3'd0));
      push(4'b0001, 8'h08, 16'd1); tick();

      // Requester 2 toggles bit 3 twice
      drive(4'b0100, 4'b0100, 4'b0100, sel_of(3'd0, 3'd0, 3'd3, 3'd0));
      push(4'b0100, 8'h00, 16'd2); tick();
      push(4'b0100, 8'h08, 16'd3); tick();

      // Hold command from requester 3 brings ptr back to 0
      drive(4'b1000, 4'b0000, 4'b0000, 12'h000);
      push(4'b1000, 8'h08, 16'd3); tick();

      // All four requesting, all hold: full rotation
      drive(4'b1111, 4'b0000, 4'b0000, 12'h000);
      push(4'b0001, 8'h08, 16'd3); push(4'b0010, 8'h08, 16'd3);
      push(4'b0100, 8'h08, 16'd3); push(4'b1000, 8'h08, 16'd3);
      push(4'b0001, 8'h08, 16'd3);
      repeat (5) tick();

      // Requester 1 sets remaining bits to reach 8'hFF
      begin
         logic [2:0] bits[7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
         logic [7:0] qs[7]   = '{8'h09, 8'h0B, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
         for (int i = 0; i < 7; i++) begin
            drive(4'b0010, 4'b0010, 4'b0000, sel_of(3'd0, bits[i], 3'd0, 3'd0));
            push(4'b0010, qs[i], 16'(4 + i)); tick();
         end
      end
      // Set of an already-set bit does not count; reset does
      drive(4'b0010, 4'b0010, 4'b0000, sel_of(3'd0, 3'd5, 3'd0, 3'd0));
      push(4'b0010, 8'hFF, 16'd10); tick();
      drive(4'b0010, 4'b0000, 4'b0010, sel_of(3'd0, 3'd5, 3'd0, 3'd0));
      push(4'b0010, 8'hDF, 16'd11); tick();

      // Same bit, consecutive grants: toggle by 2 then set by 0
      drive(4'b0101, 4'b0101, 4'b0100, sel_of(3'd0, 3'd0, 3'd0, 3'd0));
      push(4'b0100, 8'hDE, 16'd12); tick();
      drive(4'b0001, 4'b0001, 4'b0000, sel_of(3'd0, 3'd0, 3'd0, 3'd0));
      push(4'b0001, 8'hDF, 16'd13); tick();

      // Requester 0 loses to 1 then withdraws
      drive(4'b0011, 4'b0001, 4'b0001, sel_of(3'd7, 3'd0, 3'd0, 3'd0));
      push(4'b0010, 8'hDF, 16'd13); tick();
      drive(4'b0000, 4'b0000, 4'b0000, 12'h000); tick();
      chk("withdraw_q", 32'(bus.q), 32'hDF);

      // Reset mid-stream with toggles pending on every requester
      drive(4'b1111, 4'b1111, 4'b1111, 12'h000);
      rst = 1'b1;
      #1 chk("midrst_gnt", 32'(bus.gnt), 32'h0);
      tick();
      chk("midrst_q", 32'(bus.q), 32'h00);
      chk("midrst_op_cnt", 32'(bus.op_cnt), 32'h0);
      rst = 1'b0;
      drive(4'b1111, 4'b1111, 4'b1111, sel_of(3'd0, 3'd1, 3'd2, 3'd3));
      push(4'b0001, 8'h01, 16'd1); tick();
      push(4'b0010, 8'h03, 16'd2); tick();
      drive(4'b0000, 4'b0000, 4'b0000, 12'h000); tick();

      // Requester 3 toggles bit 7 until op_cnt hits FFFF, then one more wraps
      drive(4'b1000, 4'b1000, 4'b1000, sel_of(3'd0, 3'd0, 3'd0, 3'd7));
      for (int n = 1; n <= 65533; n++) begin
         push(4'b1000, (n % 2 == 1) ? 8'h83 : 8'h03, 16'(2 + n));
         tick();
      end
      push(4'b1000, 8'h03, 16'h0000); tick();
      drive(4'b0000, 4'b0000, 4'b0000, 12'h000);

      begin
         int budget = 10;
         while ((sb.size() != 0 || pend) && budget > 0) begin
            tick();
            budget--;
         end
         chk("sb_drained", 32'(sb.size()), 32'h0);
      end
      tick();
      chk("final_gnt", 32'(bus.gnt), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the JK bit bank (fixed at 4; no other value supported).
REQ-002 Parameter NBITS, default 8: number of JK state bits in the bank (fixed at 8; bit index 3 bits wide).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 req  input  4  per-requester command request; req[i] held high until gnt[i] seen.
REQ-006 j  input  4  per-requester J command bit; j[i] valid while req[i] high.
REQ-007 k  input  4  per-requester K command bit; k[i] valid while req[i] high.
REQ-008 sel  input  12  per-requester target bit index; sel[3i+2:3i] valid while req[i] high.
REQ-009 gnt  output  4  one-hot-or-zero grant, combinational from req and priority pointer.
REQ-010 q  output  8  registered JK bit bank state.
REQ-011 op_cnt  output  16  registered count of granted commands that changed a q bit.

Function
REQ-012 Arbitration SHALL be round-robin: 2-bit pointer ptr marks highest-priority requester; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); first requester with req high gets gnt.
REQ-013 At most one gnt bit SHALL be high in any cycle; gnt SHALL be all-zero when req is all-zero or rst is high.
REQ-014 A request is accepted in the cycle req[i] and gnt[i] are both high; accepted command applies at that same posedge.
REQ-015 On acceptance by requester g with index s=sel[3g+2:3g]: j=0,k=0 -> q[s] holds; j=0,k=1 -> q[s]<=0; j=1,k=0 -> q[s]<=1; j=1,k=1 -> q[s]<=~q[s].
REQ-016 Non-targeted q bits SHALL hold; update latency is one clock from acceptance edge to visible q.
REQ-017 After a grant to g, ptr SHALL become (g+1) mod 4 on the same edge; with no grant, ptr holds.
REQ-018 op_cnt SHALL increment by 1 on an accepted command only when the new q[s] differs from old q[s]; hold commands and no-effect set/reset do not count.
REQ-019 op_cnt SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-020 Requesters not granted SHALL keep req asserted; the block has no queueing and does not store ungranted commands.
REQ-021 A requester dropping req before grant SHALL be treated as withdrawn with no side effect.
REQ-022 Two requesters targeting the same bit in consecutive cycles SHALL be applied in grant order, each seeing the prior result.
REQ-023 Maximum wait for a continuously requesting requester SHALL be 3 grant cycles (starvation-free).

Reset
REQ-024 While rst high at posedge clk: q<=8'h00, op_cnt<=16'h0000, ptr<=0; no command applied even if req high.
REQ-025 rst high SHALL force gnt=4'b0000 combinationally; requests pending at reset release SHALL be arbitrated fresh from ptr=0.
REQ-026 Reset asserted mid-stream SHALL discard the command of that cycle; no partial update.

Verification
REQ-027 Reset then req=4'b0001, j[0]=1,k[0]=0, sel0=3 one cycle -> gnt=0001, next cycle q=8'h08, op_cnt=1, ptr=1.
REQ-028 q=8'h08, req[2] with j=k=1, sel2=3 for two accepted cycles -> q=8'h00 then 8'h08, op_cnt +2.
REQ-029 All four req held high, ptr=0, all hold commands -> gnt sequence 0001,0010,0100,1000,0001; q and op_cnt unchanged.
REQ-030 q=8'hFF, req[1] j=1,k=0 sel1=5 -> q stays 8'hFF, op_cnt unchanged; then j=0,k=1 -> q=8'hDF, op_cnt +1.
REQ-031 op_cnt forced to 16'hFFFF by 65535 changing commands, one more toggle -> op_cnt=16'h0000.
REQ-032 req=4'b1111 with rst high for one cycle mid-stream -> gnt=0000 that cycle, q=8'h00, op_cnt=0, next grant to requester 0.
